// File: rtl/mem_a_xfer_ctrl_pkg.sv
// Shared constants and state encoding for the memory A -> memory B
// transfer controller.
package mem_a_xfer_ctrl_pkg;

  localparam int XFER_ADDR_W = 3;
  localparam int XFER_DATA_W = 8;
  localparam int XFER_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_a_xfer_ctrl.sv
// Memory A requester: host load pass-through while idle, then a pipelined
// one-word-per-clock copy from memory A into the memory B write port.
module mem_a_xfer_ctrl
  import mem_a_xfer_ctrl_pkg::*;
#(
  parameter int ADDR_W = XFER_ADDR_W,
  parameter int DATA_W = XFER_DATA_W,
  parameter int DEPTH  = XFER_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   xfer_len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic [ADDR_W-1:0] AddrA,
  output logic              WEA,
  output logic [DATA_W-1:0] DataInA,
  input  logic [DATA_W-1:0] DOut1,
  output logic [ADDR_W-1:0] AddrB,
  output logic              WEB,
  output logic [DATA_W-1:0] DataInB,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;

  logic [ADDR_W:0]   len_in;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              wr_vld_q;
  logic              rd_last;
  logic              accept;

  assign len_in  = (xfer_len > MAX_LEN) ? MAX_LEN : xfer_len;
  assign rd_last = (rd_cnt_q == len_q - 1'b1);
  assign accept  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len_in == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rd_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Host owns port A only while idle; a transfer owns it only while reading.
  always_comb begin
    AddrA   = '0;
    WEA     = 1'b0;
    DataInA = '0;
    if (state_q == IDLE) begin
      AddrA   = host_addr;
      WEA     = host_we;
      DataInA = host_data;
    end else if (state_q == READ) begin
      AddrA = src_q + rd_cnt_q[ADDR_W-1:0];
    end
  end

  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign WEB     = wr_vld_q;
  assign AddrB   = dst_q + wr_cnt_q;
  assign DataInB = DOut1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      wr_cnt_q <= '0;
      wr_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Read data appears one edge after the read issues.
      wr_vld_q <= (state_q == READ);
      if (accept) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        len_q    <= len_in;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        if (state_q == READ) begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
        if (wr_vld_q) begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
